alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001 No parameters; all widths fixed; cmd encodings from mips_16_defs.v.
- REQ-002 clk  in  1  single clock; all state updates on rising edge.
- REQ-003 rst  in  1  reset; synchronous, active-high.
- REQ-004 req0, req1  in  1 each  operation request from requester 0 / 1; held until matching gnt seen.
- REQ-005 a0, b0, a1, b1  in  16 each  operands of requester 0 / 1; valid while req high.
- REQ-006 cmd0, cmd1  in  3 each  ALU command of requester 0 / 1.
- REQ-007 gnt0, gnt1  out  1 each  registered one-cycle grant pulse.
- REQ-008 alu_a, alu_b  out  16 each  operands to the shared alu instance.
- REQ-009 alu_cmd  out  3  command to the shared alu.
- REQ-010 alu_r  in  16  combinational result from the shared alu.
- REQ-011 r_out  out  16  registered result of the last completed operation.
- REQ-012 r_valid0, r_valid1  out  1 each  one-cycle result-valid pulse to requester 0 / 1.

Function
- REQ-013 FSM states IDLE, EXEC, DONE; IDLE->EXEC when any req high; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
- REQ-014 Arbitration only in IDLE; req sampled in any other state ignored.
- REQ-015 On IDLE->EXEC, winner's a/b/cmd latched into operand registers and winner id into owner register.
- REQ-016 In EXEC: gnt of owner = 1, other gnt = 0; alu_a/alu_b/alu_cmd driven from operand registers.
- REQ-017 Outside EXEC: alu_a = alu_b = 0, alu_cmd = ALU_NC, gnt0 = gnt1 = 0.
- REQ-018 End of EXEC: r_out <= alu_r.
- REQ-019 In DONE: r_valid of owner = 1 for exactly one cycle; other r_valid = 0.
- REQ-020 Latency: req sampled at edge t -> gnt high cycle t+1 -> r_valid high cycle t+2; one op per 3 cycles.
- REQ-021 r_out holds value until next EXEC completes; not cleared in IDLE.
- REQ-022 Requester still holding req when FSM returns to IDLE is granted a new op (back-to-back, same operands).
- REQ-023 Single req: that requester wins regardless of priority state.
- REQ-024 Simultaneous req0 and req1: winner per Configuration; loser keeps req and is served next IDLE.
- REQ-025 Any cmd value forwarded unchanged; no decode or checking in this block.

Reset
- REQ-026 rst high at edge: state = IDLE, operand/owner registers = 0, r_out = 0, all gnt/r_valid = 0, priority pointer = 0 (requester 0 favoured).
- REQ-027 rst in EXEC or DONE aborts the op: no r_valid pulse, r_out = 0, no completion later.
- REQ-028 rst overrides simultaneous req; arbitration resumes first IDLE cycle after rst low.

Configuration
- REQ-029 Macro ALU_ARB_RR_EN defined: round-robin; pointer names favoured requester on tie, updated at IDLE->EXEC to the non-winner.
- REQ-030 ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties; no pointer register.

Verification
- REQ-031 req0, a0=16'h0003, b0=16'h0004, cmd0=ALU_ADD -> gnt0 next cycle, r_valid0 and r_out=16'h0007 following cycle, gnt1/r_valid1 stay 0.
- REQ-032 req0 and req1 same cycle after reset (cmd0=ALU_SUB 5-3, cmd1=ALU_OR 16'h00F0|16'h000F) -> requester 0 first r_out=16'h0002, then requester 1 r_out=16'h00FF; with ALU_ARB_RR_EN a repeated tie serves requester 1 first.
- REQ-033 Without ALU_ARB_RR_EN, req0 and req1 held continuously -> only requester 0 granted (starvation of 1 expected).
- REQ-034 req1 with cmd1=ALU_SR, a1=16'h8000, b1=16'h0004 -> r_out=16'hF800 on r_valid1; alu_cmd=ALU_NC in IDLE/DONE cycles.
- REQ-035 rst asserted in EXEC cycle of a pending ADD -> no r_valid pulse, r_out=0, state IDLE; new req granted after rst low.
- REQ-036 req0 held 6 cycles -> two complete ops, gnt0 pulses 3 cycles apart.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// Each operation runs IDLE -> EXEC -> DONE. The grant pulse is in EXEC and
// the result-valid pulse is in DONE.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie breaking.
// Without it, requester 0 always wins a tie.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic [2:0]  cmd0,
  input  logic [2:0]  cmd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_cmd,
  input  logic [15:0] alu_r,
  output logic [15:0] r_out,
  output logic        r_valid0,
  output logic        r_valid1
);

  // Idle command code, matching ALU_NC in mips_16_defs.v
  localparam logic [2:0] ALU_NC = 3'd0;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state, state_nxt;
  logic        take;
  logic        win;
  logic        owner;
  logic [15:0] op_a, op_b;
  logic [2:0]  op_cmd;

`ifdef ALU_ARB_RR_EN
  logic ptr;

  // Round-robin pointer: after each grant, it favours whichever requester did not win
  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (take) ptr <= ~win;
  end

  // Pick the winner: a lone requester wins, and the pointer settles a tie
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ptr;
    else if (req1)    win = 1'b1;
  end
`else
  // Pick the winner: requester 0 has fixed priority, so requester 1 wins only when alone
  always_comb begin
    win = 1'b0;
    if (req1 && !req0) win = 1'b1;
  end
`endif

  // Next-state logic; requests are looked at only while idle
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = EXEC;
          take      = 1'b1;
        end
      end
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the winner's operands and identity when an operation starts
  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= 1'b0;
      op_a   <= 16'h0000;
      op_b   <= 16'h0000;
      op_cmd <= ALU_NC;
    end else if (take) begin
      owner  <= win;
      op_a   <= win ? a1 : a0;
      op_b   <= win ? b1 : b0;
      op_cmd <= win ? cmd1 : cmd0;
    end
  end

  // Registered grant and valid pulses, plus a result that is held until the next EXEC ends
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_out    <= 16'h0000;
    end else begin
      gnt0     <= take && !win;
      gnt1     <= take && win;
      r_valid0 <= (state == EXEC) && !owner;
      r_valid1 <= (state == EXEC) && owner;
      if (state == EXEC) r_out <= alu_r;
    end
  end

  // Drive the shared ALU only in EXEC; at all other times it sees zeros and the no-op command
  always_comb begin
    alu_a   = 16'h0000;
    alu_b   = 16'h0000;
    alu_cmd = ALU_NC;
    if (state == EXEC) begin
      alu_a   = op_a;
      alu_b   = op_b;
      alu_cmd = op_cmd;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random requests for alu_arbiter.
// A behavioural ALU is attached to the arbiter's ALU port.
// A cycle-level reference model tracks expected outputs.
module tb_alu_arbiter;

  localparam logic [2:0] ALU_NC  = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SL  = 3'd6;
  localparam logic [2:0] ALU_SR  = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic [2:0]  cmd0, cmd1;
  logic        gnt0, gnt1;
  logic [15:0] alu_a, alu_b, alu_r, r_out;
  logic [2:0]  alu_cmd;
  logic        r_valid0, r_valid1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: the number of cycles left in the current operation, plus the expected outputs
  int          m_left = 0;
  bit          m_owner, m_ptr;
  logic [15:0] m_res, m_rout, m_a, m_b;
  logic [2:0]  m_cmd;
  bit          m_gnt0, m_gnt1, m_rv0, m_rv1;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cmd0(cmd0), .cmd1(cmd1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_r(alu_r),
    .r_out(r_out), .r_valid0(r_valid0), .r_valid1(r_valid1)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  function automatic logic [15:0] alu_fn(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] sa;
    sa = a;
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SL:  return a << b[3:0];
      ALU_SR:  return 16'(sa >>> b[3:0]);
      default: return 16'h0000;
    endcase
  endfunction

  // The shared ALU instance that the arbiter drives
  always_comb alu_r = alu_fn(alu_cmd, alu_a, alu_b);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [15:0] xa0, input logic [15:0] xb0, input logic [2:0] c0,
                               input logic r1, input logic [15:0] xa1, input logic [15:0] xb1, input logic [2:0] c1);
    req0 = r0; a0 = xa0; b0 = xb0; cmd0 = c0;
    req1 = r1; a1 = xa1; b1 = xb1; cmd1 = c1;
  endtask

  // Advance the model by one rising edge, using the inputs that were sampled at that edge
  task automatic model_edge();
    m_gnt0 = 0; m_gnt1 = 0; m_rv0 = 0; m_rv1 = 0;
    if (rst) begin
      m_left = 0; m_rout = 16'h0000; m_ptr = 0;
      m_a = 16'h0000; m_b = 16'h0000; m_cmd = ALU_NC;
    end else if (m_left == 2) begin
      m_rout = m_res;
      if (m_owner) m_rv1 = 1; else m_rv0 = 1;
      m_left = 1;
    end else if (m_left == 1) begin
      m_left = 0;
    end else if (req0 || req1) begin
      if (req0 && req1) begin
`ifdef ALU_ARB_RR_EN
        m_owner = m_ptr;
`else
        m_owner = 0;
`endif
      end else begin
        m_owner = req1;
      end
      m_ptr = !m_owner;
      m_a   = m_owner ? a1 : a0;
      m_b   = m_owner ? b1 : b0;
      m_cmd = m_owner ? cmd1 : cmd0;
      m_res = alu_fn(m_cmd, m_a, m_b);
      if (m_owner) m_gnt1 = 1; else m_gnt0 = 1;
      m_left = 2;
    end
  endtask

  task automatic checkOutput();
    chk("gnt0", 16'(gnt0), 16'(m_gnt0));
    chk("gnt1", 16'(gnt1), 16'(m_gnt1));
    chk("r_valid0", 16'(r_valid0), 16'(m_rv0));
    chk("r_valid1", 16'(r_valid1), 16'(m_rv1));
    chk("r_out", r_out, m_rout);
    chk("alu_a", alu_a, (m_left == 2) ? m_a : 16'h0000);
    chk("alu_b", alu_b, (m_left == 2) ? m_b : 16'h0000);
    chk("alu_cmd", 16'(alu_cmd), 16'((m_left == 2) ? m_cmd : ALU_NC));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    checkOutput();
  endtask

  initial begin
    int g0, g1, last_g0, gap;
    m_rout = 16'h0000; m_a = 16'h0000; m_b = 16'h0000; m_cmd = ALU_NC; m_res = 16'h0000;
    m_ptr = 0; m_owner = 0;
    applyStimulus(0, 0, 0, ALU_NC, 0, 0, 0, ALU_NC);

    $display("[TB] reset");
    rst = 1; step(); step();
    chk("reset_r_out", r_out, 16'h0000);
    rst = 0;

    $display("[TB] single ADD from requester 0");
    applyStimulus(1, 16'h0003, 16'h0004, ALU_ADD, 0, 0, 0, ALU_NC);
    step();
    chk("add_gnt0", 16'(gnt0), 16'h0001);
    req0 = 0;
    step();
    chk("add_rv0", 16'(r_valid0), 16'h0001);
    chk("add_r_out", r_out, 16'h0007);
    step();
    chk("add_r_out_held", r_out, 16'h0007);

    $display("[TB] simultaneous SUB and OR after reset");
    rst = 1; step(); rst = 0;
    applyStimulus(1, 16'h0005, 16'h0003, ALU_SUB, 1, 16'h00F0, 16'h000F, ALU_OR);
    step();
    chk("tie_gnt0_first", 16'(gnt0), 16'h0001);
    req0 = 0;
    step();
    chk("tie_r_out_0", r_out, 16'h0002);
    step(); step();
    chk("tie_gnt1_second", 16'(gnt1), 16'h0001);
    req1 = 0;
    step();
    chk("tie_r_out_1", r_out, 16'h00FF);
    chk("tie_rv1", 16'(r_valid1), 16'h0001);
    step();

    $display("[TB] both requests held continuously");
    applyStimulus(1, 16'h0011, 16'h0022, ALU_XOR, 1, 16'h0101, 16'h0001, ALU_SL);
    g0 = 0; g1 = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      g0 += int'(gnt0); g1 += int'(gnt1);
    end
`ifdef ALU_ARB_RR_EN
    chk("held_gnt0_count", 16'(g0), 16'd2);
    chk("held_gnt1_count", 16'(g1), 16'd1);
`else
    chk("held_gnt0_count", 16'(g0), 16'd3);
    chk("held_gnt1_count", 16'(g1), 16'd0);
`endif
    req0 = 0; req1 = 0;
    step(); step(); step();

    $display("[TB] arithmetic shift right from requester 1");
    applyStimulus(0, 0, 0, ALU_NC, 1, 16'h8000, 16'h0004, ALU_SR);
    step();
    req1 = 0;
    step();
    chk("sr_rv1", 16'(r_valid1), 16'h0001);
    chk("sr_r_out", r_out, 16'hF800);
    chk("sr_done_cmd", 16'(alu_cmd), 16'(ALU_NC));
    step();

    $display("[TB] reset during EXEC");
    applyStimulus(1, 16'h0001, 16'h0002, ALU_ADD, 0, 0, 0, ALU_NC);
    step();
    chk("abort_gnt0", 16'(gnt0), 16'h0001);
    rst = 1;
    step();
    chk("abort_rv0", 16'(r_valid0), 16'h0000);
    chk("abort_r_out", r_out, 16'h0000);
    rst = 0;
    step();
    chk("abort_regrant", 16'(gnt0), 16'h0001);
    req0 = 0;
    step();
    chk("abort_new_r_out", r_out, 16'h0003);
    step();

    $display("[TB] requester 0 held six cycles");
    applyStimulus(1, 16'h00AA, 16'h0055, ALU_AND, 0, 0, 0, ALU_NC);
    g0 = 0; last_g0 = -1; gap = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (gnt0) begin
        if (last_g0 >= 0) gap = i - last_g0;
        last_g0 = i;
        g0++;
      end
    end
    chk("b2b_gnt0_count", 16'(g0), 16'd2);
    chk("b2b_gnt0_gap", 16'(gap), 16'd3);
    req0 = 0;
    step(); step(); step();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (req0 && gnt0) begin
        if ($urandom_range(0, 3) != 0) req0 = 0;
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; a0 = 16'($urandom); b0 = 16'($urandom); cmd0 = 3'($urandom);
      end
      if (req1 && gnt1) begin
        if ($urandom_range(0, 3) != 0) req1 = 0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; a1 = 16'($urandom); b1 = 16'($urandom); cmd1 = 3'($urandom);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
